irq_controller: RTL and testbench

Parametrised interrupt/exception controller for the MIPS32 core, replacing the fixed five-source IRQ OR-tree and the free-running EPC/Cause registers. It accepts NSRC request lines: the low NEXC lines are synchronous, non-maskable exceptions, and the rest are edge-latched, maskable interrupts. It arbitrates by fixed priority and tracks kernel mode. It captures EPC and Cause only when a trap is actually taken, and supports return-from-exception. It sits beside the PC register: the core loads VECTOR into PC and suppresses register-file and memory writes whenever Take is high.

---
 rtl/irq_controller.sv | 137 +++++++++++++
 tb/tb_irq_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Parametrised interrupt/exception controller: fixed-priority arbitration,
// edge-latched maskable interrupts, level exceptions, EPC/Cause capture on trap.
module irq_controller #(
    parameter int          NSRC      = 5,
    parameter int          NEXC      = 1,
    parameter logic [31:0] VECTOR    = 32'h8000_0008,
    parameter logic [31:0] RESET_EPC = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NSRC-1:0] i_src,
    input  logic [31:0]     i_pc,
    input  logic            i_eret,
    input  logic            i_wr_en,
    input  logic [1:0]      i_addr,
    input  logic [31:0]     i_wr_data,
    output logic [31:0]     o_rd_data,
    output logic            o_take,
    output logic [31:0]     o_vector,
    output logic [31:0]     o_epc_out,
    output logic            o_kmode
);

    function automatic logic [NSRC-1:0] f_exc_mask();
        logic [NSRC-1:0] m;
        m = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (i < NEXC) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NSRC-1:0] EXC_MASK = f_exc_mask();

    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [31:0]     r_epc;
    logic [31:0]     r_cause;
    logic            r_kbit;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_exc_req;
    logic [NSRC-1:0] w_int_elig;
    logic [NSRC-1:0] w_req;
    logic            w_take;
    logic            w_win_exc;
    logic [4:0]      w_win_idx;
    logic [NSRC-1:0] w_win_oh;
    logic [NSRC-1:0] w_snap;
    logic [31:0]     w_cause_nxt;
    logic [NSRC-1:0] w_clr_take;
    logic [NSRC-1:0] w_clr_w1c;
    logic [NSRC-1:0] w_pending_nxt;
    logic            w_wr_mask;
    logic            w_wr_cause;
    logic            w_wr_epc;
    logic            w_wr_status;

    // Exception lines are never latched, so rising edges only matter on interrupt lines.
    assign w_rise     = i_src & ~r_src_q & ~EXC_MASK;
    assign w_exc_req  = i_src & EXC_MASK;
    assign w_int_elig = r_pending & r_mask & ~EXC_MASK & {NSRC{~r_kbit}};
    assign w_req      = w_exc_req | w_int_elig;
    assign w_take     = |w_req;
    assign w_win_exc  = |w_exc_req;

    always_comb begin
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_idx   = 5'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    assign w_snap      = r_pending | w_exc_req;
    assign w_cause_nxt = {w_win_exc, 10'b0, w_win_idx, 16'(w_snap)};

    assign w_wr_mask   = i_wr_en && (i_addr == 2'd0);
    assign w_wr_cause  = i_wr_en && (i_addr == 2'd1) && !w_take;
    assign w_wr_epc    = i_wr_en && (i_addr == 2'd2) && !w_take;
    assign w_wr_status = i_wr_en && (i_addr == 2'd3) && !w_take;

    assign w_clr_take    = (w_take && !w_win_exc) ? w_win_oh : '0;
    assign w_clr_w1c     = w_wr_cause ? i_wr_data[NSRC-1:0] : '0;
    // A fresh edge on a line overrides any clear aimed at it in the same cycle.
    assign w_pending_nxt = (r_pending & ~(w_clr_take | w_clr_w1c)) | w_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src_q   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_src_q   <= i_src;
            r_pending <= w_pending_nxt;
            if (w_wr_mask) r_mask <= i_wr_data[NSRC-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_epc   <= RESET_EPC;
            r_cause <= '0;
            r_kbit  <= 1'b1;
        end else if (w_take) begin
            // Nested traps keep the EPC of the outermost one.
            r_kbit  <= 1'b1;
            r_cause <= w_cause_nxt;
            if (!r_kbit) r_epc <= i_pc;
        end else begin
            if (w_wr_epc) r_epc <= i_wr_data;
            if (w_wr_status) r_kbit <= i_wr_data[0];
            else if (i_eret) r_kbit <= 1'b0;
        end
    end

    always_comb begin
        o_rd_data = '0;
        case (i_addr)
            2'd0:    o_rd_data = 32'(r_mask);
            2'd1:    o_rd_data = r_cause;
            2'd2:    o_rd_data = r_epc;
            default: o_rd_data = {31'b0, r_kbit};
        endcase
    end

    assign o_take    = w_take;
    assign o_vector  = VECTOR;
    assign o_epc_out = r_epc;
    assign o_kmode   = r_kbit;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected values are queued as
// stimulus is applied and compared against sampled DUT outputs.
module tb_irq_controller;

    localparam logic [31:0] VEC  = 32'h8000_0008;
    localparam logic [31:0] REPC = 32'h8000_0000;

    localparam int S_TAKE = 0;
    localparam int S_KM   = 1;
    localparam int S_EPC  = 2;
    localparam int S_RD   = 3;
    localparam int S_VEC  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  src;
    logic [31:0] pc;
    logic        eret;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        take;
    logic [31:0] vector;
    logic [31:0] epc_out;
    logic        kmode;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    irq_controller #(
        .NSRC(5), .NEXC(1), .VECTOR(VEC), .RESET_EPC(REPC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_src(src), .i_pc(pc), .i_eret(eret),
        .i_wr_en(wr_en), .i_addr(addr), .i_wr_data(wr_data),
        .o_rd_data(rd_data), .o_take(take), .o_vector(vector),
        .o_epc_out(epc_out), .o_kmode(kmode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_TAKE:  return {31'b0, take};
            S_KM:    return {31'b0, kmode};
            S_EPC:   return epc_out;
            S_RD:    return rd_data;
            default: return vector;
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] val);
        addr = a;
        sb_push(tag, S_RD, val);
        drain();
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    initial begin
        rst = 1'b1; src = '0; pc = '0; eret = 1'b0;
        wr_en = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        sb_push("rst_take", S_TAKE, 32'd0);
        sb_push("rst_kmode", S_KM, 32'd1);
        sb_push("rst_epc", S_EPC, REPC);
        sb_push("vector", S_VEC, VEC);
        drain();
        rd(2'd0, "rst_mask", 32'h0000_001F);
        rd(2'd1, "rst_cause", 32'h0);
        rd(2'd3, "rst_status", 32'h1);
        rst = 1'b0;
        tick();

        // Single interrupt: one cycle after the pending edge
        csr_wr(2'd3, 32'h0);
        sb_push("t1_kmode_clr", S_KM, 32'd0);
        drain();
        src = 5'b00100; pc = 32'h0000_0040;
        sb_push("t1_no_take_same_cycle", S_TAKE, 32'd0);
        drain();
        tick();
        sb_push("t1_take", S_TAKE, 32'd1);
        drain();
        tick();
        sb_push("t1_take_after", S_TAKE, 32'd0);
        sb_push("t1_kmode", S_KM, 32'd1);
        sb_push("t1_epc", S_EPC, 32'h0000_0040);
        drain();
        rd(2'd1, "t1_cause", 32'h0002_0004);
        csr_wr(2'd3, 32'h0);
        sb_push("t1_no_repend", S_TAKE, 32'd0);
        drain();
        src = '0;
        tick();

        // Simultaneous rises: priority, Eret, then the lower-priority line
        src = 5'b01010; pc = 32'h0000_0200;
        tick();
        sb_push("t2_take1", S_TAKE, 32'd1);
        drain();
        tick();
        sb_push("t2_kmode1", S_KM, 32'd1);
        sb_push("t2_epc1", S_EPC, 32'h0000_0200);
        sb_push("t2_blocked", S_TAKE, 32'd0);
        drain();
        rd(2'd1, "t2_cause1", 32'h0001_000A);
        eret = 1'b1;
        tick();
        eret = 1'b0; pc = 32'h0000_0300;
        sb_push("t2_eret_kmode", S_KM, 32'd0);
        sb_push("t2_take3", S_TAKE, 32'd1);
        drain();
        tick();
        sb_push("t2_epc3", S_EPC, 32'h0000_0300);
        sb_push("t2_kmode3", S_KM, 32'd1);
        drain();
        rd(2'd1, "t2_cause3", 32'h0003_0008);
        src = '0;
        tick();

        // Exception while already in kernel mode keeps EPC
        csr_wr(2'd2, 32'h0000_0100);
        src = 5'b00001; pc = 32'h8000_0020;
        sb_push("t3_exc_take", S_TAKE, 32'd1);
        drain();
        tick();
        src = '0;
        sb_push("t3_epc_kept", S_EPC, 32'h0000_0100);
        sb_push("t3_kmode", S_KM, 32'd1);
        drain();
        rd(2'd1, "t3_cause", 32'h8000_0001);

        // Masked pending, then unmask
        csr_wr(2'd0, 32'h0000_001B);
        csr_wr(2'd3, 32'h0);
        src = 5'b00100;
        tick();
        sb_push("t4_masked", S_TAKE, 32'd0);
        drain();
        tick();
        sb_push("t4_masked_hold", S_TAKE, 32'd0);
        drain();
        csr_wr(2'd0, 32'h0000_001F);
        sb_push("t4_unmask_take", S_TAKE, 32'd1);
        drain();
        tick();
        rd(2'd1, "t4_cause", 32'h0002_0004);
        src = '0;
        tick();
        // W1C discards a masked pending request
        csr_wr(2'd0, 32'h0000_001B);
        csr_wr(2'd3, 32'h0);
        src = 5'b00100;
        tick();
        csr_wr(2'd1, 32'h0000_0004);
        csr_wr(2'd0, 32'h0000_001F);
        sb_push("t4_w1c_no_take", S_TAKE, 32'd0);
        sb_push("t4_w1c_kmode", S_KM, 32'd0);
        drain();
        src = '0;
        tick();

        // Take beats Eret and a concurrent EPC write
        csr_wr(2'd2, 32'h0000_1234);
        csr_wr(2'd3, 32'h1);
        eret = 1'b1; src = 5'b00001; pc = 32'h0000_0999;
        wr_en = 1'b1; addr = 2'd2; wr_data = 32'hDEAD_BEEF;
        sb_push("t5_take", S_TAKE, 32'd1);
        drain();
        tick();
        eret = 1'b0; src = '0; wr_en = 1'b0; wr_data = '0;
        sb_push("t5_kmode", S_KM, 32'd1);
        sb_push("t5_epc", S_EPC, 32'h0000_1234);
        drain();

        // Set beats W1C on the same line, then asynchronous reset
        csr_wr(2'd0, 32'h0000_000F);
        csr_wr(2'd3, 32'h0);
        src = 5'b10000;
        wr_en = 1'b1; addr = 2'd1; wr_data = 32'h0000_0010;
        tick();
        wr_en = 1'b0; wr_data = '0;
        sb_push("t6_masked", S_TAKE, 32'd0);
        drain();
        csr_wr(2'd0, 32'h0000_001F);
        sb_push("t6_set_wins", S_TAKE, 32'd1);
        drain();
        rst = 1'b1;
        src = '0;
        sb_push("t6_rst_take", S_TAKE, 32'd0);
        sb_push("t6_rst_kmode", S_KM, 32'd1);
        sb_push("t6_rst_epc", S_EPC, REPC);
        drain();
        rd(2'd0, "t6_rst_mask", 32'h0000_001F);
        tick();
        rst = 1'b0;
        tick();
        csr_wr(2'd3, 32'h0);
        sb_push("t6_pend_cleared", S_TAKE, 32'd0);
        sb_push("t6_kmode_clr", S_KM, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
